// File: rtl/tl_buffer_3.sv
// tl_buffer_3: TileLink A/D channel buffer.
// A path is always a 2-entry registered FIFO (no flow-through, no pipe bypass).
// Optional feature macro BUFFER_D_QUEUE_EN: when defined the D path gets an
// identical 2-entry FIFO; when undefined the D path is a combinational wire.

// Two-entry FIFO with registered ready/valid. Payload is opaque to the queue.
module tl_buffer_3_queue #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enq_valid,
   output logic         enq_ready,
   input  logic [W-1:0] enq_bits,
   output logic         deq_valid,
   input  logic         deq_ready,
   output logic [W-1:0] deq_bits
);
   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wptr_q, wptr_d;
   logic              rptr_q, rptr_d;
   logic [1:0]        count_q, count_d;
   logic              enq, deq;

   // Ready/valid come only from the occupancy register: a full queue refuses
   // input even while it is being drained, and a fresh beat appears next cycle.
   assign enq_ready = (count_q != 2'd2);
   assign deq_valid = (count_q != 2'd0);
   assign deq_bits  = mem_q[rptr_q];
   assign enq       = enq_valid && enq_ready;
   assign deq       = deq_valid && deq_ready;

   // Next-state: write at wptr on enqueue, advance rptr on dequeue, track count.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq) begin
         mem_d[wptr_q] = enq_bits;
         wptr_d        = ~wptr_q;
      end
      if (deq) begin
         rptr_d = ~rptr_q;
      end
      if (enq && !deq) begin
         count_d = count_q + 2'd1;
      end else if (!enq && deq) begin
         count_d = count_q - 2'd1;
      end
   end

   // State register; reset discards every buffered beat and clears storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q   <= '0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
endmodule

module tl_buffer_3 (
   input  logic        clock,
   input  logic        reset,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [3:0]  auto_in_a_bits_size,
   input  logic [3:0]  auto_in_a_bits_source,
   input  logic [31:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   output logic        auto_in_a_ready,
   output logic        auto_out_a_valid,
   output logic [2:0]  auto_out_a_bits_opcode,
   output logic [2:0]  auto_out_a_bits_param,
   output logic [3:0]  auto_out_a_bits_size,
   output logic [3:0]  auto_out_a_bits_source,
   output logic [31:0] auto_out_a_bits_address,
   output logic [7:0]  auto_out_a_bits_mask,
   output logic [63:0] auto_out_a_bits_data,
   output logic        auto_out_a_bits_corrupt,
   input  logic        auto_out_a_ready,
   input  logic        auto_out_d_valid,
   input  logic [2:0]  auto_out_d_bits_opcode,
   input  logic [1:0]  auto_out_d_bits_param,
   input  logic [3:0]  auto_out_d_bits_size,
   input  logic [3:0]  auto_out_d_bits_source,
   input  logic [3:0]  auto_out_d_bits_sink,
   input  logic        auto_out_d_bits_denied,
   input  logic [63:0] auto_out_d_bits_data,
   input  logic        auto_out_d_bits_corrupt,
   output logic        auto_out_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [3:0]  auto_in_d_bits_size,
   output logic [3:0]  auto_in_d_bits_source,
   output logic [3:0]  auto_in_d_bits_sink,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_corrupt,
   input  logic        auto_in_d_ready
);
   localparam int AW = 119;
   localparam int DW = 83;

   logic [AW-1:0] a_enq_bits, a_deq_bits;

   // Fields are packed into one word so the queue never looks inside a beat.
   assign a_enq_bits = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                        auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                        auto_in_a_bits_data, auto_in_a_bits_corrupt};
   assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq_bits;

   tl_buffer_3_queue #(.W(AW)) u_a_queue (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (auto_in_a_valid),
      .enq_ready (auto_in_a_ready),
      .enq_bits  (a_enq_bits),
      .deq_valid (auto_out_a_valid),
      .deq_ready (auto_out_a_ready),
      .deq_bits  (a_deq_bits)
   );

`ifdef BUFFER_D_QUEUE_EN
   logic [DW-1:0] d_enq_bits, d_deq_bits;

   assign d_enq_bits = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                        auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                        auto_out_d_bits_data, auto_out_d_bits_corrupt};
   assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq_bits;

   tl_buffer_3_queue #(.W(DW)) u_d_queue (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (auto_out_d_valid),
      .enq_ready (auto_out_d_ready),
      .enq_bits  (d_enq_bits),
      .deq_valid (auto_in_d_valid),
      .deq_ready (auto_in_d_ready),
      .deq_bits  (d_deq_bits)
   );
`else
   // Unbuffered D: zero-latency wire-through, no state.
   assign auto_in_d_valid        = auto_out_d_valid;
   assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in_d_bits_param   = auto_out_d_bits_param;
   assign auto_in_d_bits_size    = auto_out_d_bits_size;
   assign auto_in_d_bits_source  = auto_out_d_bits_source;
   assign auto_in_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in_d_bits_data    = auto_out_d_bits_data;
   assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;
   assign auto_out_d_ready       = auto_in_d_ready;
`endif
endmodule

// File: tb/tb_tl_buffer_3.sv
// Directed + random bench for tl_buffer_3 with a queue scoreboard per channel.
module tb_tl_buffer_3;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        in_a_valid, in_a_ready, out_a_valid, out_a_ready;
   logic        out_d_valid, out_d_ready, in_d_valid, in_d_ready;
   logic [118:0] a_in, a_out;
   logic [82:0]  d_in, d_out;

   logic [2:0]  ia_opcode, ia_param, oa_opcode, oa_param;
   logic [3:0]  ia_size, ia_source, oa_size, oa_source;
   logic [31:0] ia_address, oa_address;
   logic [7:0]  ia_mask, oa_mask;
   logic [63:0] ia_data, oa_data;
   logic        ia_corrupt, oa_corrupt;

   logic [2:0]  od_opcode, id_opcode;
   logic [1:0]  od_param, id_param;
   logic [3:0]  od_size, od_source, od_sink, id_size, id_source, id_sink;
   logic        od_denied, od_corrupt, id_denied, id_corrupt;
   logic [63:0] od_data, id_data;

   assign {ia_opcode, ia_param, ia_size, ia_source, ia_address, ia_mask, ia_data, ia_corrupt} = a_in;
   assign a_out = {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask, oa_data, oa_corrupt};
   assign {od_opcode, od_param, od_size, od_source, od_sink, od_denied, od_data, od_corrupt} = d_in;
   assign d_out = {id_opcode, id_param, id_size, id_source, id_sink, id_denied, id_data, id_corrupt};

   tl_buffer_3 dut (
      .clock(clock), .reset(reset),
      .auto_in_a_valid(in_a_valid),
      .auto_in_a_bits_opcode(ia_opcode), .auto_in_a_bits_param(ia_param),
      .auto_in_a_bits_size(ia_size), .auto_in_a_bits_source(ia_source),
      .auto_in_a_bits_address(ia_address), .auto_in_a_bits_mask(ia_mask),
      .auto_in_a_bits_data(ia_data), .auto_in_a_bits_corrupt(ia_corrupt),
      .auto_in_a_ready(in_a_ready),
      .auto_out_a_valid(out_a_valid),
      .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
      .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
      .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
      .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
      .auto_out_a_ready(out_a_ready),
      .auto_out_d_valid(out_d_valid),
      .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_param(od_param),
      .auto_out_d_bits_size(od_size), .auto_out_d_bits_source(od_source),
      .auto_out_d_bits_sink(od_sink), .auto_out_d_bits_denied(od_denied),
      .auto_out_d_bits_data(od_data), .auto_out_d_bits_corrupt(od_corrupt),
      .auto_out_d_ready(out_d_ready),
      .auto_in_d_valid(in_d_valid),
      .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_param(id_param),
      .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_source),
      .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
      .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
      .auto_in_d_ready(in_d_ready)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [118:0] a_sb[$];
   logic [82:0]  d_sb[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [118:0] mk_a(input logic [31:0] addr);
      logic [63:0] data;
      data = {$urandom, $urandom};
      return {3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), addr,
              8'($urandom), data, 1'($urandom)};
   endfunction

   // Called mid low-phase: check outputs against the model, record handshakes,
   // then advance one clock to the next falling edge.
   task automatic step();
      chk("a_valid", out_a_valid, a_sb.size() != 0);
      chk("a_ready", in_a_ready, a_sb.size() < 2);
      if (out_a_valid && a_sb.size() != 0) begin
         chk(out_a_ready ? "a_deq" : "a_hold", a_out, a_sb[0]);
         if (out_a_ready) void'(a_sb.pop_front());
      end
      if (in_a_valid && in_a_ready) a_sb.push_back(a_in);
`ifdef BUFFER_D_QUEUE_EN
      chk("d_valid", in_d_valid, d_sb.size() != 0);
      chk("d_ready", out_d_ready, d_sb.size() < 2);
      if (in_d_valid && d_sb.size() != 0) begin
         chk(in_d_ready ? "d_deq" : "d_hold", d_out, d_sb[0]);
         if (in_d_ready) void'(d_sb.pop_front());
      end
      if (out_d_valid && out_d_ready) d_sb.push_back(d_in);
`endif
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      in_a_valid = 1'b0; out_a_ready = 1'b0; a_in = '0;
      out_d_valid = 1'b0; in_d_ready = 1'b0; d_in = '0;
      @(negedge clock);
      @(negedge clock);
      // Reset state
      chk("rst_in_a_ready", in_a_ready, 1);
      chk("rst_out_a_valid", out_a_valid, 0);
      chk("rst_out_a_bits", a_out, 0);
`ifdef BUFFER_D_QUEUE_EN
      chk("rst_out_d_ready", out_d_ready, 1);
      chk("rst_in_d_valid", in_d_valid, 0);
      chk("rst_in_d_bits", d_out, 0);
`endif
      reset = 1'b0;
      step();

      // Single beat, one-cycle latency
      out_a_ready = 1'b1;
      in_a_valid = 1'b1; a_in = mk_a(32'h8000_0000);
      chk("lat_no_flowthrough", out_a_valid, 0);
      step();
      in_a_valid = 1'b0;
      chk("lat_addr", oa_address, 32'h8000_0000);
      step();
      step();

      // Fill, full refuses third beat, drain in order
      out_a_ready = 1'b0;
      in_a_valid = 1'b1; a_in = mk_a(32'h10); step();
      a_in = mk_a(32'h20); step();
      a_in = mk_a(32'h30);
      chk("full_refuses", in_a_ready, 0);
      step();
      step();
      out_a_ready = 1'b1;
      chk("full_drain_first", oa_address, 32'h10);
      step();                       // 0x10 leaves, still full at edge: 0x30 held
      step();                       // 0x20 leaves, 0x30 accepted
      in_a_valid = 1'b0;
      chk("full_drain_last", oa_address, 32'h30);
      step();
      step();

      // Simultaneous enqueue/dequeue at count 1
      out_a_ready = 1'b0;
      in_a_valid = 1'b1; a_in = mk_a(32'h10); step();
      out_a_ready = 1'b1; a_in = mk_a(32'h20); step();
      in_a_valid = 1'b0;
      chk("simul_count1_ready", in_a_ready, 1);
      chk("simul_next_addr", oa_address, 32'h20);
      step();
      step();

      // Reset mid-operation with two beats buffered
      out_a_ready = 1'b0;
      in_a_valid = 1'b1; a_in = mk_a(32'h44); step();
      a_in = mk_a(32'h55); step();
      in_a_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst_out_a_valid", out_a_valid, 0);
      chk("midrst_in_a_ready", in_a_ready, 1);
      chk("midrst_out_a_bits", a_out, 0);
      a_sb.delete();
      @(negedge clock);
      reset = 1'b0;
      out_a_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Random traffic on A
      for (int i = 0; i < 300; i++) begin
         in_a_valid = 1'($urandom);
         a_in = mk_a($urandom);
         out_a_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_a_valid = 1'b0;
      out_a_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

`ifdef BUFFER_D_QUEUE_EN
      // Queued D: payload held stable under backpressure, one delivery
      in_d_ready = 1'b0;
      out_d_valid = 1'b1;
      d_in = {3'd1, 2'd0, 4'd3, 4'd5, 4'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      step();
      out_d_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("d_hold_source", id_source, 5);
         chk("d_hold_data", id_data, 64'hDEAD_BEEF_CAFE_F00D);
         step();
      end
      in_d_ready = 1'b1;
      step();
      chk("d_single_delivery", in_d_valid, 0);
      for (int i = 0; i < 200; i++) begin
         out_d_valid = 1'($urandom);
         d_in = {19'($urandom), $urandom, $urandom};
         in_d_ready = ($urandom_range(0, 3) != 0);
         in_a_valid = 1'($urandom);
         a_in = mk_a($urandom);
         out_a_ready = 1'($urandom);
         step();
      end
`else
      // Unbuffered D: same-cycle pass-through
      out_d_valid = 1'b1;
      in_d_ready = 1'b0;
      d_in = {3'd1, 2'd1, 4'd3, 4'd3, 4'd7, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};
      #1;
      chk("dwire_valid", in_d_valid, 1);
      chk("dwire_source", id_source, 3);
      chk("dwire_bits", d_out, d_in);
      chk("dwire_ready0", out_d_ready, 0);
      in_d_ready = 1'b1;
      #1;
      chk("dwire_ready1", out_d_ready, 1);
      out_d_valid = 1'b0;
      #1;
      chk("dwire_valid0", in_d_valid, 0);
      @(negedge clock);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
